// File: rtl/bus_trace_monitor_if.sv
// Bus and trace-port bundle for bus_trace_monitor.
// master: the side driving the 8085 bus (ale, s0, s1, io_mn, rdn, wrn, ad, addr_hi) and the
//         trace consumer handshake (trace_ready); it observes the trace outputs.
// slave:  the monitor; it samples the bus and drives trace_data, trace_valid, ovf_cnt,
//         proto_err and done.
interface bus_trace_monitor_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned TS_W   = 16
);
  localparam int unsigned RecW = 3 + ADDR_W + DATA_W + TS_W;

  logic                     ale;
  logic                     s0;
  logic                     s1;
  logic                     io_mn;
  logic                     rdn;
  logic                     wrn;
  logic [DATA_W-1:0]        ad;
  logic [ADDR_W-DATA_W-1:0] addr_hi;
  logic [RecW-1:0]          trace_data;
  logic                     trace_valid;
  logic                     trace_ready;
  logic [7:0]               ovf_cnt;
  logic                     proto_err;
  logic                     done;

  modport master (
    output ale, s0, s1, io_mn, rdn, wrn, ad, addr_hi, trace_ready,
    input  trace_data, trace_valid, ovf_cnt, proto_err, done
  );

  modport slave (
    input  ale, s0, s1, io_mn, rdn, wrn, ad, addr_hi, trace_ready,
    output trace_data, trace_valid, ovf_cnt, proto_err, done
  );
endinterface

// File: rtl/bus_trace_monitor.sv
// Decodes 8085 bus cycles into {fetch, io, wr, addr, data, ts} records and buffers them in a
// first-word fall-through FIFO.
// Ports:
//   clk  - system clock, all logic on posedge
//   rst  - synchronous active-high reset
//   bus  - bus_trace_monitor_if.slave: bus inputs, trace FIFO read port, ovf_cnt, proto_err,
//          done
module bus_trace_monitor #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned TS_W       = 16,
  parameter int unsigned MAX_CYCLES = 23
) (
  input logic                clk,
  input logic                rst,
  bus_trace_monitor_if.slave bus
);
  localparam int unsigned RecW = 3 + ADDR_W + DATA_W + TS_W;
  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [2:0] {StIdle, StAddr, StWait, StStrobe, StPush} state_e;

  state_e state_q, state_d;

  logic [TS_W-1:0]   ts_q;
  logic [31:0]       cyc_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [TS_W-1:0]   rec_ts_q;
  logic              io_q, wr_q, fetch_q;
  logic              proto_err_q;
  logic [7:0]        ovf_q;

  logic [RecW-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q;

  logic both_low, one_low, strobe_high;
  logic addr_en, cap_en, data_en, push_en;
  logic empty, full, pop, push_ok, drop;

  assign both_low    = ~bus.rdn & ~bus.wrn;
  assign one_low     = bus.rdn ^ bus.wrn;
  // The strobe that opened this cycle decides when it ends.
  assign strobe_high = wr_q ? bus.wrn : bus.rdn;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; a protocol fault or the cycle limit parks the FSM in idle.
  always_comb begin
    state_d = state_q;
    if (both_low || done_q) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   if (bus.ale) state_d = StAddr;
        StAddr:   if (!bus.ale) state_d = StWait;
        StWait: begin
          if (one_low)      state_d = StStrobe;
          else if (bus.ale) state_d = StAddr;
        end
        StStrobe: if (strobe_high) state_d = StPush;
        StPush:   state_d = bus.ale ? StAddr : StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Output / enable decode
  always_comb begin
    addr_en = 1'b0;
    cap_en  = 1'b0;
    data_en = 1'b0;
    push_en = 1'b0;
    // Latch on every edge heading into ADDR so a one-clock ALE still captures the address.
    if (state_d == StAddr && bus.ale) addr_en = 1'b1;
    if (state_q == StWait && state_d == StStrobe) cap_en = 1'b1;
    if (state_d == StStrobe) data_en = 1'b1;
    if (state_q == StPush && !both_low) push_en = 1'b1;
  end

  // Record fields, timestamp, cycle limit and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q        <= '0;
      cyc_q       <= '0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rec_ts_q    <= '0;
      io_q        <= 1'b0;
      wr_q        <= 1'b0;
      fetch_q     <= 1'b0;
      proto_err_q <= 1'b0;
      ovf_q       <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (!done_q) begin
        cyc_q <= cyc_q + 32'd1;
        if (MAX_CYCLES != 0 && (cyc_q + 32'd1) == MAX_CYCLES) done_q <= 1'b1;
      end
      if (addr_en) addr_q <= {bus.addr_hi, bus.ad};
      if (cap_en) begin
        io_q     <= bus.io_mn;
        wr_q     <= ~bus.wrn;
        fetch_q  <= bus.wrn & bus.s1 & bus.s0;
        rec_ts_q <= ts_q;
      end
      if (data_en) data_q <= bus.ad;
      if (both_low) proto_err_q <= 1'b1;
      if (drop && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
    end
  end

  // Trace FIFO
  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW+1)'(DEPTH));
  assign pop     = ~empty & bus.trace_ready;
  // A full FIFO still accepts a record when the head leaves on the same edge.
  assign push_ok = push_en & (~full | pop);
  assign drop    = push_en & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {fetch_q, io_q, wr_q, addr_q, data_q, rec_ts_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.trace_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.trace_valid = ~empty;
  assign bus.ovf_cnt     = ovf_q;
  assign bus.proto_err   = proto_err_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_bus_trace_monitor.sv
module tb_bus_trace_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ale = 1'b0, s0 = 1'b0, s1 = 1'b0, io_mn = 1'b0, rdn = 1'b1, wrn = 1'b1;
  logic [7:0] ad = 8'h00, addr_hi = 8'h00;
  logic ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // bus0 never hits the cycle limit; bus1 uses the default limit of 23.
  bus_trace_monitor_if #(.DATA_W(8), .ADDR_W(16), .TS_W(16)) bus0 ();
  bus_trace_monitor_if #(.DATA_W(8), .ADDR_W(16), .TS_W(16)) bus1 ();

  assign bus0.ale = ale;   assign bus1.ale = ale;
  assign bus0.s0 = s0;     assign bus1.s0 = s0;
  assign bus0.s1 = s1;     assign bus1.s1 = s1;
  assign bus0.io_mn = io_mn; assign bus1.io_mn = io_mn;
  assign bus0.rdn = rdn;   assign bus1.rdn = rdn;
  assign bus0.wrn = wrn;   assign bus1.wrn = wrn;
  assign bus0.ad = ad;     assign bus1.ad = ad;
  assign bus0.addr_hi = addr_hi; assign bus1.addr_hi = addr_hi;
  assign bus0.trace_ready = ready;
  assign bus1.trace_ready = ready;

  bus_trace_monitor #(.DATA_W(8), .ADDR_W(16), .DEPTH(16), .TS_W(16), .MAX_CYCLES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  bus_trace_monitor #(.DATA_W(8), .ADDR_W(16), .DEPTH(16), .TS_W(16), .MAX_CYCLES(23)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Record layout: [42] fetch, [41] io, [40] wr, [39:24] addr, [23:16] data, [15:0] ts
  logic [42:0] td;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ale = 1'b0; rdn = 1'b1; wrn = 1'b1; ready = 1'b0;
    io_mn = 1'b0; s1 = 1'b0; s0 = 1'b0; ad = 8'h00; addr_hi = 8'h00;
    tick();
    rst = 1'b0;
  endtask

  task automatic pop_one();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  // Seven clocks: ALE, address phase end, strobe low for 3 edges, strobe high, push edge.
  task automatic bus_cycle(input logic is_wr, input logic io, input logic [1:0] st,
                           input logic [15:0] addr, input logic [7:0] data,
                           input bit pop_at_push);
    ale = 1'b1; addr_hi = addr[15:8]; ad = addr[7:0]; io_mn = io; {s1, s0} = st;
    tick();
    ale = 1'b0; ad = data;
    tick();
    if (is_wr) wrn = 1'b0; else rdn = 1'b0;
    tick(); tick(); tick();
    rdn = 1'b1; wrn = 1'b1;
    tick();
    if (pop_at_push) ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus0.trace_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got %b expected 0", bus0.trace_valid); end
    checks++; if (bus0.trace_data !== 43'h0) begin errors++;
      $display("FAIL reset_data: got %h expected 0", bus0.trace_data); end
    checks++; if (bus0.ovf_cnt !== 8'h00) begin errors++;
      $display("FAIL reset_ovf: got %h expected 00", bus0.ovf_cnt); end
    checks++; if (bus0.proto_err !== 1'b0) begin errors++;
      $display("FAIL reset_proto: got %b expected 0", bus0.proto_err); end
    checks++; if (bus1.done !== 1'b0) begin errors++;
      $display("FAIL reset_done: got %b expected 0", bus1.done); end
  endtask

  task automatic test_mem_read();
    ale = 1'b1; addr_hi = 8'h12; ad = 8'h34; io_mn = 1'b0; {s1, s0} = 2'b10;
    tick();
    ale = 1'b0; ad = 8'hA5;
    tick();
    rdn = 1'b0;
    tick(); tick(); tick();
    rdn = 1'b1;
    tick();
    checks++; if (bus0.trace_valid !== 1'b0) begin errors++;
      $display("FAIL read_valid_early: got %b expected 0", bus0.trace_valid); end
    tick();
    checks++; if (bus0.trace_valid !== 1'b1) begin errors++;
      $display("FAIL read_valid: got %b expected 1", bus0.trace_valid); end
    td = bus0.trace_data;
    checks++; if (td[39:24] !== 16'h1234) begin errors++;
      $display("FAIL read_addr: got %h expected 1234", td[39:24]); end
    checks++; if (td[23:16] !== 8'hA5) begin errors++;
      $display("FAIL read_data: got %h expected a5", td[23:16]); end
    checks++; if (td[42:40] !== 3'b000) begin errors++;
      $display("FAIL read_flags: got %b expected 000", td[42:40]); end
    pop_one();
    checks++; if (bus0.trace_valid !== 1'b0) begin errors++;
      $display("FAIL read_drained: got %b expected 0", bus0.trace_valid); end
  endtask

  task automatic test_fetch_io();
    logic [15:0] ts1;
    bus_cycle(1'b0, 1'b0, 2'b11, 16'h0000, 8'h3E, 1'b0);
    bus_cycle(1'b1, 1'b1, 2'b01, 16'h0080, 8'h55, 1'b0);
    td = bus0.trace_data;
    checks++; if (td[42:40] !== 3'b100 || td[39:24] !== 16'h0000 || td[23:16] !== 8'h3E) begin
      errors++; $display("FAIL fetch_rec: got %h expected flags 100 addr 0000 data 3e", td);
    end
    ts1 = td[15:0];
    pop_one();
    td = bus0.trace_data;
    checks++; if (td[42:40] !== 3'b011 || td[39:24] !== 16'h0080 || td[23:16] !== 8'h55) begin
      errors++; $display("FAIL io_wr_rec: got %h expected flags 011 addr 0080 data 55", td);
    end
    checks++; if (!(td[15:0] > ts1)) begin errors++;
      $display("FAIL ts_order: got %h expected above %h", td[15:0], ts1); end
    pop_one();
  endtask

  task automatic test_overflow();
    int pops;
    logic [7:0] first_d, last_d;
    for (int i = 0; i < 20; i++) bus_cycle(1'b0, 1'b0, 2'b10, 16'h2000 + 16'(i), 8'h10 + 8'(i), 1'b0);
    checks++; if (bus0.ovf_cnt !== 8'd4) begin errors++;
      $display("FAIL ovf_cnt: got %0d expected 4", bus0.ovf_cnt); end
    td = bus0.trace_data;
    checks++; if (td[39:24] !== 16'h2000 || td[23:16] !== 8'h10) begin errors++;
      $display("FAIL ovf_head: got %h/%h expected 2000/10", td[39:24], td[23:16]); end
    bus_cycle(1'b0, 1'b0, 2'b10, 16'h2014, 8'h24, 1'b1);
    checks++; if (bus0.ovf_cnt !== 8'd4) begin errors++;
      $display("FAIL full_push_pop_ovf: got %0d expected 4", bus0.ovf_cnt); end
    pops = 0; first_d = 8'h00; last_d = 8'h00;
    ready = 1'b1;
    while (bus0.trace_valid === 1'b1 && pops < 40) begin
      td = bus0.trace_data;
      if (pops == 0) first_d = td[23:16];
      last_d = td[23:16];
      pops++;
      tick();
    end
    ready = 1'b0;
    checks++; if (pops !== 16) begin errors++;
      $display("FAIL drain_count: got %0d expected 16", pops); end
    checks++; if (first_d !== 8'h11) begin errors++;
      $display("FAIL drain_first: got %h expected 11", first_d); end
    checks++; if (last_d !== 8'h24) begin errors++;
      $display("FAIL drain_last: got %h expected 24", last_d); end
  endtask

  task automatic test_rst_mid_strobe();
    // ovf_cnt is still 4 from the overflow scenario.
    bus_cycle(1'b0, 1'b0, 2'b10, 16'h3000, 8'h66, 1'b0);
    rdn = 1'b0; wrn = 1'b0;
    tick();
    rdn = 1'b1; wrn = 1'b1;
    tick();
    ale = 1'b1; addr_hi = 8'h40; ad = 8'h00;
    tick();
    ale = 1'b0; ad = 8'h99;
    tick();
    rdn = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++; if (bus0.trace_valid !== 1'b0 || bus0.trace_data !== 43'h0) begin errors++;
      $display("FAIL rst_fifo: got valid %b data %h expected 0/0", bus0.trace_valid,
               bus0.trace_data); end
    checks++; if (bus0.ovf_cnt !== 8'h00 || bus0.proto_err !== 1'b0) begin errors++;
      $display("FAIL rst_flags: got ovf %h proto %b expected 00/0", bus0.ovf_cnt,
               bus0.proto_err); end
    rst = 1'b0; rdn = 1'b1;
    tick(); tick(); tick();
    checks++; if (bus0.trace_valid !== 1'b0) begin errors++;
      $display("FAIL rst_partial: got %b expected 0", bus0.trace_valid); end
  endtask

  task automatic test_fault();
    do_reset();
    ale = 1'b1; addr_hi = 8'h50; ad = 8'h00;
    tick();
    ale = 1'b0;
    tick();
    rdn = 1'b0; wrn = 1'b0;
    tick();
    rdn = 1'b1; wrn = 1'b1;
    tick(); tick();
    checks++; if (bus0.proto_err !== 1'b1 || bus0.trace_valid !== 1'b0) begin errors++;
      $display("FAIL proto: got err %b valid %b expected 1/0", bus0.proto_err,
               bus0.trace_valid); end
    ale = 1'b1; addr_hi = 8'h11; ad = 8'h11;
    tick();
    ale = 1'b0;
    tick();
    ale = 1'b1; addr_hi = 8'h22; ad = 8'h22;
    tick();
    ale = 1'b0; ad = 8'h77;
    tick();
    checks++; if (bus0.trace_valid !== 1'b0) begin errors++;
      $display("FAIL abandon_norec: got %b expected 0", bus0.trace_valid); end
    rdn = 1'b0;
    tick(); tick();
    rdn = 1'b1;
    tick(); tick();
    td = bus0.trace_data;
    checks++; if (bus0.trace_valid !== 1'b1 || td[39:24] !== 16'h2222 || td[23:16] !== 8'h77)
    begin errors++;
      $display("FAIL after_abandon: got valid %b addr %h data %h expected 1/2222/77",
               bus0.trace_valid, td[39:24], td[23:16]); end
    pop_one();
    checks++; if (bus0.proto_err !== 1'b1 || bus0.trace_valid !== 1'b0) begin errors++;
      $display("FAIL proto_sticky: got err %b valid %b expected 1/0", bus0.proto_err,
               bus0.trace_valid); end
  endtask

  task automatic test_limit();
    do_reset();
    bus_cycle(1'b0, 1'b0, 2'b10, 16'h6000, 8'h42, 1'b0);
    repeat (15) tick();
    checks++; if (bus1.done !== 1'b0 || bus1.trace_valid !== 1'b1) begin errors++;
      $display("FAIL done_early: got done %b valid %b expected 0/1", bus1.done,
               bus1.trace_valid); end
    tick();
    checks++; if (bus1.done !== 1'b1) begin errors++;
      $display("FAIL done_rise: got %b expected 1", bus1.done); end
    bus_cycle(1'b0, 1'b0, 2'b10, 16'h7000, 8'h43, 1'b0);
    td = bus1.trace_data;
    checks++; if (td[39:24] !== 16'h6000 || bus1.done !== 1'b1) begin errors++;
      $display("FAIL done_head: got addr %h done %b expected 6000/1", td[39:24], bus1.done); end
    pop_one();
    checks++; if (bus1.trace_valid !== 1'b0) begin errors++;
      $display("FAIL done_norec: got %b expected 0", bus1.trace_valid); end
    checks++; if (bus0.done !== 1'b0 || bus0.trace_valid !== 1'b1) begin errors++;
      $display("FAIL nolimit: got done %b valid %b expected 0/1", bus0.done,
               bus0.trace_valid); end
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_fetch_io();
    test_overflow();
    test_rst_mid_strobe();
    test_fault();
    test_limit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
